// File: rtl/icache_line_fill_pkg.sv
// Shared riscv package slice used by the icache line-fill engine:
// geometry constants and the fill FSM state encoding.
package riscv_pkg;

  localparam int ICACHE_ADDR_W     = 64;
  localparam int ICACHE_LINE_W     = 128;
  localparam int ICACHE_BUS_W      = 32;
  localparam int ICACHE_LINE_BYTES = 16;
  localparam int ICACHE_BEATS      = ICACHE_LINE_W / ICACHE_BUS_W;

  // Fill engine states.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } fill_state_t;

endpackage

// File: rtl/icache_line_fill_if.sv
// Instruction memory bus seen by the line-fill engine: one beat request
// with grant, followed by a single read response.
interface icache_line_fill_if
  import riscv_pkg::*;
#(
  parameter int ADDR_W = ICACHE_ADDR_W,
  parameter int BUS_W  = ICACHE_BUS_W
) ();

  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [BUS_W-1:0]  bus_rdata;
  logic              bus_rerr;

  // Fill engine side: issues requests, consumes responses.
  modport master (
    output bus_req,
    output bus_addr,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata,
    input  bus_rerr
  );

  // Memory side: grants requests, returns responses.
  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata,
    output bus_rerr
  );

endinterface

// File: rtl/icache_line_fill.sv
// Icache line-fill engine: fetches one 16-byte block as four sequential
// 32-bit bus reads, assembles a 128-bit line and reports it with a
// one-cycle mem_ready pulse. Supports abort with draining of the single
// outstanding beat.
module icache_line_fill
  import riscv_pkg::*;
#(
  parameter int ADDR_W = ICACHE_ADDR_W,
  parameter int LINE_W = ICACHE_LINE_W,
  parameter int BUS_W  = ICACHE_BUS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_rden,
  input  logic                 addr_sel,
  input  logic [ADDR_W-1:0]    pc,
  output logic                 mem_ready,
  output logic [LINE_W-1:0]    line_data,
  output logic                 fill_err,
  icache_line_fill_if.master   bus
);

  localparam int OFF_BITS  = $clog2(ICACHE_LINE_BYTES);
  localparam int BEAT_BITS = $clog2(ICACHE_BEATS);
  localparam int BYTE_BITS = $clog2(BUS_W / 8);

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(ICACHE_BEATS - 1);

  fill_state_t           state, state_next;
  logic [BEAT_BITS-1:0]  beat;
  logic [ADDR_W-1:0]     base;
  logic [LINE_W-1:0]     line;
  logic                  err_acc;

  logic                  start;
  logic                  beat_wr;
  logic                  beat_inc;
  logic [ADDR_W-1:0]     base_next;

  // Block base of the fill target: the pc block, or the next one for the
  // misaligned second half. The addition wraps at ADDR_W bits.
  assign base_next = {pc[ADDR_W-1:OFF_BITS], OFF_BITS'(0)}
                   + (addr_sel ? ADDR_W'(ICACHE_LINE_BYTES) : '0);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    beat_wr    = 1'b0;
    beat_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_rden) begin
          start      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (!mem_rden) begin
          // A grant in the abort cycle still leaves a response in flight.
          state_next = bus.bus_gnt ? DRAIN : IDLE;
        end else if (bus.bus_gnt) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!mem_rden) begin
          // A response arriving in the abort cycle is the outstanding one,
          // so there is nothing left to drain.
          state_next = bus.bus_rvalid ? IDLE : DRAIN;
        end else if (bus.bus_rvalid) begin
          beat_wr = 1'b1;
          if (beat == LAST_BEAT) begin
            state_next = DONE;
          end else begin
            beat_inc   = 1'b1;
            state_next = REQ;
          end
        end
      end
      DONE: begin
        // mem_rden is deliberately not looked at here.
        state_next = IDLE;
      end
      DRAIN: begin
        if (bus.bus_rvalid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Fill datapath: base address, beat counter, line assembly, error OR.
  // NOTE: the line register is reset even though it is wide, because
  // line_data is a visible output whose reset value is defined as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base    <= '0;
      beat    <= '0;
      line    <= '0;
      err_acc <= 1'b0;
    end else begin
      if (start) begin
        base    <= base_next;
        beat    <= '0;
        err_acc <= 1'b0;
      end
      if (beat_wr) begin
        line[int'(beat)*BUS_W +: BUS_W] <= bus.bus_rdata;
        err_acc                         <= err_acc | bus.bus_rerr;
      end
      if (beat_inc) begin
        beat <= beat + 1'b1;
      end
    end
  end

  // Outputs are decoded from state or taken straight from registers.
  assign mem_ready    = (state == DONE);
  assign fill_err     = err_acc;
  assign line_data    = line;
  assign bus.bus_req  = (state == REQ);
  assign bus.bus_addr = base + ADDR_W'({beat, BYTE_BITS'(0)});

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: a configurable memory
// responder, a table of directed fills, hand-written multi-cycle
// sequences (back-to-back, abort, reset) and randomized fills checked
// against a block-level reference model.
module tb_icache_line_fill;
  import riscv_pkg::*;

  localparam int ADDR_W = 64;
  localparam int LINE_W = 128;
  localparam int BUS_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_rden;
  logic              addr_sel;
  logic [ADDR_W-1:0] pc;
  logic              mem_ready;
  logic [LINE_W-1:0] line_data;
  logic              fill_err;

  icache_line_fill_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus ();

  icache_line_fill #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BUS_W(BUS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rden  (mem_rden),
    .addr_sel  (addr_sel),
    .pc        (pc),
    .mem_ready (mem_ready),
    .line_data (line_data),
    .fill_err  (fill_err),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory behaviour, keyed by the word index inside the block.
  int unsigned       gnt_dly [4];
  int unsigned       rv_dly  [4];
  logic              err_beat[4];
  logic [BUS_W-1:0]  word    [4];
  logic [ADDR_W-1:0] granted [$];

  // Memory responder: grants after gnt_dly idle cycles, answers rv_dly
  // cycles after the grant, one outstanding beat. Not affected by rst.
  initial begin
    int                resp_cnt;
    int                gnt_wait;
    logic [ADDR_W-1:0] resp_addr;
    logic [ADDR_W-1:0] hold_addr;
    resp_cnt = -1;
    gnt_wait = 0;
    resp_addr = '0;
    hold_addr = '0;
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = '0;
    bus.bus_rerr   = 1'b0;
    forever begin
      @(negedge clk);
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b0;
      bus.bus_rerr   = 1'b0;
      bus.bus_rdata  = $urandom;
      if (resp_cnt == 0) begin
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata  = word[resp_addr[3:2]];
        bus.bus_rerr   = err_beat[resp_addr[3:2]];
        resp_cnt       = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end else if (bus.bus_req && !rst) begin
        if (gnt_wait == 0) hold_addr = bus.bus_addr;
        else check("addr_stable", bus.bus_addr, hold_addr);
        if (gnt_wait == int'(gnt_dly[hold_addr[3:2]])) begin
          bus.bus_gnt = 1'b1;
          granted.push_back(bus.bus_addr);
          resp_addr = bus.bus_addr;
          resp_cnt  = int'(rv_dly[hold_addr[3:2]]);
          gnt_wait  = 0;
        end else begin
          gnt_wait++;
        end
      end else begin
        gnt_wait = 0;
      end
    end
  end

  task automatic clear_cfg();
    for (int k = 0; k < 4; k++) begin
      gnt_dly[k]  = 0;
      rv_dly[k]   = 0;
      err_beat[k] = 1'b0;
      word[k]     = $urandom;
    end
  endtask

  // Start a fill in the next cycle and check latency, line, error and the
  // beat addresses. With keep set, mem_rden stays high and the task returns
  // in the mem_ready cycle so the caller can chain another fill.
  task automatic run_fill(input string tag, input logic [63:0] p, input logic s,
                          input logic [63:0] exp_base, input int exp_lat,
                          input logic exp_err, input bit keep);
    int           lat;
    logic [127:0] exp_line;
    exp_line = {word[3], word[2], word[1], word[0]};
    granted.delete();
    @(negedge clk);
    pc       = p;
    addr_sel = s;
    mem_rden = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 200);
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " line_data"}, line_data, exp_line);
    check({tag, " fill_err"}, 128'(fill_err), 128'(exp_err));
    check({tag, " beats"}, 128'(granted.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < granted.size())
        check({tag, $sformatf(" addr%0d", k)}, 128'(granted[k]), 128'(exp_base + 64'(4 * k)));
    end
    if (!keep) begin
      mem_rden = 1'b0;
      @(negedge clk);
      check({tag, " ready_pulse"}, 128'(mem_ready), 128'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_ready"}, 128'(mem_ready), 128'd0);
    check({tag, " bus_req"}, 128'(bus.bus_req), 128'd0);
    check({tag, " bus_addr"}, 128'(bus.bus_addr), 128'd0);
    check({tag, " line_data"}, line_data, 128'd0);
    check({tag, " fill_err"}, 128'(fill_err), 128'd0);
  endtask

  typedef struct {
    logic [63:0]       pc;
    logic              sel;
    logic [3:0][1:0]   gd;
    logic [3:0][1:0]   rd;
    logic [3:0]        er;
    logic [3:0][31:0]  w;
    logic [63:0]       exp_base;
    int                exp_lat;
    logic              exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cnt_ready;
    int cnt_req;
    int guard;

    rst      = 1'b1;
    mem_rden = 1'b0;
    addr_sel = 1'b0;
    pc       = '0;
    clear_cfg();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed fills: zero-wait, stalled, error, clean after error,
    // mixed delays with error, address wrap.
    vecs[0] = '{64'h1008, 1'b0, 8'h00, 8'h00, 4'b0000,
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 64'h1000, 9, 1'b0};
    vecs[1] = '{64'h3000, 1'b0, {2'd0, 2'd0, 2'd3, 2'd0}, {2'd0, 2'd2, 2'd0, 2'd0}, 4'b0000,
                {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000}, 64'h3000, 14, 1'b0};
    vecs[2] = '{64'h4024, 1'b0, 8'h00, 8'h00, 4'b0100,
                {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}, 64'h4020, 9, 1'b1};
    vecs[3] = '{64'h4024, 1'b1, 8'h00, 8'h00, 4'b0000,
                {32'hBEEF_0003, 32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000}, 64'h4030, 9, 1'b0};
    vecs[4] = '{64'h0005_0000_0000_1230, 1'b1, {2'd0, 2'd2, 2'd0, 2'd1}, {2'd2, 2'd0, 2'd1, 2'd0}, 4'b0001,
                {32'h5555_AAAA, 32'h1234_5678, 32'h0F0F_0F0F, 32'hFFFF_0000}, 64'h0005_0000_0000_1240, 15, 1'b1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFF4, 1'b1, 8'h00, 8'h00, 4'b0000,
                {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000}, 64'h0, 9, 1'b0};

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        gnt_dly[k]  = int'(vecs[i].gd[k]);
        rv_dly[k]   = int'(vecs[i].rd[k]);
        err_beat[k] = vecs[i].er[k];
        word[k]     = vecs[i].w[k];
      end
      run_fill($sformatf("vec%0d", i), vecs[i].pc, vecs[i].sel, vecs[i].exp_base,
               vecs[i].exp_lat, vecs[i].exp_err, 1'b0);
    end

    // Misaligned pair: second fill starts in the cycle after mem_ready.
    clear_cfg();
    run_fill("pair0", 64'h200E, 1'b0, 64'h2000, 9, 1'b0, 1'b1);
    clear_cfg();
    run_fill("pair1", 64'h200E, 1'b1, 64'h2010, 9, 1'b0, 1'b0);

    // Abort while waiting for beat 1 response.
    clear_cfg();
    rv_dly[1] = 3;
    granted.delete();
    @(negedge clk);
    pc       = 64'h6000;
    addr_sel = 1'b0;
    mem_rden = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (granted.size() < 2 && guard < 50);
    check("abort grant1", 128'(granted.size()), 128'd2);
    @(negedge clk);
    mem_rden = 1'b0;
    cnt_ready = 0;
    cnt_req   = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_ready) cnt_ready++;
      if (bus.bus_req) cnt_req++;
    end
    check("abort no_ready", 128'(cnt_ready), 128'd0);
    check("abort no_req", 128'(cnt_req), 128'd0);
    check("abort beats", 128'(granted.size()), 128'd2);
    clear_cfg();
    run_fill("post_abort", 64'h6008, 1'b1, 64'h6010, 9, 1'b0, 1'b0);

    // Reset pulsed while waiting for beat 2; its response arrives late.
    clear_cfg();
    rv_dly[2] = 4;
    granted.delete();
    @(negedge clk);
    pc       = 64'h7004;
    addr_sel = 1'b0;
    mem_rden = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (granted.size() < 3 && guard < 50);
    check("rst grant2", 128'(granted.size()), 128'd3);
    @(negedge clk);
    rst      = 1'b1;
    mem_rden = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    cnt_ready = 0;
    cnt_req   = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready) cnt_ready++;
      if (bus.bus_req) cnt_req++;
    end
    check("rst no_ready", 128'(cnt_ready), 128'd0);
    check("rst no_req", 128'(cnt_req), 128'd0);
    check_reset_outputs("rst_late");

    // Randomized fills against the block-level model.
    for (int i = 0; i < 24; i++) begin
      logic [63:0] p;
      logic        s;
      logic [63:0] eb;
      int          el;
      logic        ee;
      p  = {$urandom, $urandom};
      s  = 1'($urandom_range(0, 1));
      el = 9;
      ee = 1'b0;
      for (int k = 0; k < 4; k++) begin
        gnt_dly[k]  = $urandom_range(0, 2);
        rv_dly[k]   = $urandom_range(0, 2);
        err_beat[k] = ($urandom_range(0, 7) == 0);
        word[k]     = $urandom;
        el += int'(gnt_dly[k]) + int'(rv_dly[k]);
        ee |= err_beat[k];
      end
      eb = {p[63:4], 4'b0000} + (s ? 64'd16 : 64'd0);
      run_fill($sformatf("rnd%0d", i), p, s, eb, el, ee, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Line-fill engine between the instruction-cache controller and the instruction memory bus. On a fill request from the icache FSM (`mem_rden`), it fetches one 16-byte cache block as four sequential 32-bit bus reads and assembles them into a 128-bit line. It returns the line with a one-cycle `mem_ready` pulse, which the icache FSM uses to write the instruction array. It serves both the indexed block (ALLOCATE_1) and the following block for misaligned fetches (ALLOCATE_2, `addr_sel`=1).

## Interface
- `ADDR_W`, 64, fetch address width
- `LINE_W`, 128, cache block width (fixed 16 bytes, block_offset 4 bits)
- `BUS_W`, 32, memory data beat width; BEATS = LINE_W/BUS_W = 4
- Clock and reset: reset `rst`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  clock
- `rst`  in  1  async active-high reset
- `mem_rden`  in  1  fill request from icache FSM, level, held until `mem_ready`
- `addr_sel`  in  1  0: block containing `pc`; 1: next sequential block
- `pc`  in  ADDR_W  current fetch address
- `mem_ready`  out  1  one-cycle pulse: `line_data` valid, fill done
- `line_data`  out  LINE_W  assembled block, beat k in bits [32k+31:32k]
- `fill_err`  out  1  valid with `mem_ready`: at least one beat returned `bus_rerr`
- `bus_req`  out  1  beat read request
- `bus_addr`  out  ADDR_W  beat byte address, word aligned
- `bus_gnt`  in  1  request accepted this cycle
- `bus_rvalid`  in  1  read response valid
- `bus_rdata`  in  BUS_W  read response data
- `bus_rerr`  in  1  response error, qualified by `bus_rvalid`

## Operation
- Values after reset: state IDLE, beat counter 0, `mem_ready`=0, `bus_req`=0, `bus_addr`=0, `line_data`=0, `fill_err`=0.
- IDLE: the block samples `mem_rden`=1.
  - It latches base = {pc[ADDR_W-1:4], 4'b0} + (addr_sel ? 16 : 0), using ADDR_W-bit wrap-around addition.
  - It clears the beat counter and the error accumulator, then moves to REQ.
- REQ: `bus_req`=1 and `bus_addr`=base + 4·beat.
  - Both are held stable until `bus_gnt`.
  - On `bus_gnt`, the block moves to WAIT.
  - Only one beat is outstanding at a time.
- WAIT: `bus_req`=0.
  - On `bus_rvalid`, the block writes `bus_rdata` into slice `beat` of the line register and ORs `bus_rerr` into the error accumulator.
  - If beat=3, it moves to DONE. Otherwise it increments the beat counter and returns to REQ.
- DONE: `mem_ready`=1 for exactly one cycle, with `fill_err` equal to the accumulator. The block then returns to IDLE.
  - `mem_rden` is ignored in DONE, so no new fill can start in the `mem_ready` cycle.
- `line_data` is held from DONE until the first beat write of the next fill. The icache writes it at the negedge of the `mem_ready` cycle.
- Abort: `mem_rden`=0 while in REQ or WAIT.
  - In REQ before `bus_gnt`: `bus_req` drops and the block returns to IDLE.
  - In REQ with `bus_gnt` in the same cycle, or in WAIT: the block moves to DRAIN.
  - DRAIN waits for the outstanding `bus_rvalid`, discards the data, and goes to IDLE.
  - No `mem_ready` is produced for an aborted fill.
- `bus_rvalid` outside WAIT and DRAIN is ignored.
- Back-to-back fills (ALLOCATE_1 then ALLOCATE_2): the second fill starts from IDLE in the cycle after DONE, using the current `addr_sel`.
- Reset asserted mid-fill: the block returns immediately to its reset values. A late `bus_rvalid` after reset is ignored, because the block is in IDLE.

## Timing
- Zero-wait bus (`bus_gnt` in the request cycle, `bus_rvalid` one cycle later):
  - `mem_rden` is sampled in cycle N.
  - Beat k is requested in cycle N+1+2k; its data returns in cycle N+2+2k.
  - `mem_ready` is asserted in cycle N+9.
- Each cycle of `bus_gnt` or `bus_rvalid` delay adds one cycle of latency.
- All outputs are registered or decoded from state only. There is no combinational path from bus inputs to `mem_ready` or `bus_req`.

## Structure
- The shared package `riscv_pkg` holds:
  - the `ICACHE_LINE_BYTES`=16 and `ICACHE_BEATS`=4 constants;
  - the `fill_state_t` enum {IDLE, REQ, WAIT, DONE, DRAIN}.
- Single module, no sub-modules. State register, 2-bit beat counter, base address register, line register, error flag.

## Test plan
- Zero-wait fill: pc=0x1008, addr_sel=0, words 0xA0..0xA3 → `bus_addr` 0x1000, 0x1004, 0x1008, 0x100C; `mem_ready` at N+9; `line_data`=0x000000A3_000000A2_000000A1_000000A0; `fill_err`=0.
- Misaligned pair: pc=0x200E. First fill with addr_sel=0 uses base 0x2000 and produces `mem_ready`. A fill started in the next cycle with addr_sel=1 uses base 0x2010, with no overlap and one `mem_ready` per fill.
- Stalled bus: `bus_gnt` delayed 3 cycles on beat 1 and `bus_rvalid` delayed 2 cycles on beat 2 → `bus_addr` stable while waiting; `mem_ready` at N+14.
- Error: `bus_rerr`=1 on beat 2 only → `mem_ready` with `fill_err`=1; the next clean fill gives `fill_err`=0.
- Abort: `mem_rden` drops in WAIT of beat 1 → no further `bus_req`; the outstanding response is drained; no `mem_ready`; IDLE, and a new fill then works normally.
- Wrap and reset: pc=0xFFFF_FFFF_FFFF_FFF4 with addr_sel=1 → base 0x0. `rst` pulsed mid-beat 2 → all outputs return to their reset values, and a late `bus_rvalid` has no effect.
